leve1_wb_csr: RTL and testbench

//  Write-back stage and machine-mode CSR bank for the LEVE1 RV64 pipeline. Consumes the EX stage

---
 rtl/leve_pkg.sv | 86 ++++++++
 rtl/leve1_regfile.sv | 45 ++++
 rtl/leve1_wb_csr.sv | 138 +++++++++++++
 tb/tb_leve1_wb_csr.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/leve_pkg.sv
// LEVE1 shared definitions: CSR map, privilege modes,
// the mstatus layout and CSR operation codes.
package leve_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [1:0] MODE_M = 2'b11;
    localparam logic [1:0] MODE_U = 2'b00;

    localparam logic [6:0]  OPC_SYSTEM  = 7'b1110011;
    localparam logic [31:0] INSTR_MRET  = 32'h3020_0073;
    localparam logic [63:0] MISA_VAL    = 64'h8000_0000_0010_1100;
    localparam logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_0000;

    typedef struct packed {
        logic        sd;
        logic [26:0] wpri4;
        logic [1:0]  sxl;
        logic [1:0]  uxl;
        logic [8:0]  wpri3;
        logic        tsr;
        logic        tw;
        logic        tvm;
        logic        mxr;
        logic        sum;
        logic        mprv;
        logic [1:0]  xs;
        logic [1:0]  fs;
        logic [1:0]  mpp;
        logic [1:0]  wpri2;
        logic        spp;
        logic        mpie;
        logic        wpri1;
        logic        spie;
        logic        upie;
        logic        mie;
        logic        wpri0;
        logic        sie;
        logic        uie;
    } mstatus_f_t;

    typedef union packed {
        logic [63:0] raw;
        mstatus_f_t  f;
    } mstatus_t;

    typedef enum logic [1:0] {
        CSR_NONE,
        CSR_WRITE,
        CSR_SET,
        CSR_CLEAR
    } csr_op_e;

    function automatic csr_op_e csr_op(input logic [2:0] f3);
        case (f3)
            3'b001, 3'b101: csr_op = CSR_WRITE;
            3'b010, 3'b110: csr_op = CSR_SET;
            3'b011, 3'b111: csr_op = CSR_CLEAR;
            default:        csr_op = CSR_NONE;
        endcase
    endfunction

    // Addresses that accept writes; everything else drops them.
    function automatic logic csr_rw(input logic [11:0] a);
        case (a)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
            CSR_MCYCLE, CSR_MINSTRET: csr_rw = 1'b1;
            default:                  csr_rw = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/leve1_regfile.sv
// 32 x XLEN integer register file, 2 read / 1 write.
// Ports: clk_i, rst_i, write port we_i/waddr_i/wdata_i,
// read ports raddr{1,2}_i -> rdata{1,2}_o (write-first, x0 = 0).
module leve1_regfile #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [32];
    logic            wr;

    assign wr = we_i && (waddr_i != 5'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wr) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = '0;
        if (raddr1_i != 5'd0) begin
            rdata1_o = (wr && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
        end
    end

    always_comb begin
        rdata2_o = '0;
        if (raddr2_i != 5'd0) begin
            rdata2_o = (wr && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/leve1_wb_csr.sv
// LEVE1 write-back stage plus machine-mode CSR bank and MRET.
// Ports: EX_* commit inputs, ID_* read ports, MSTATUS/MODE state, WB_* redirect.
module leve1_wb_csr
    import leve_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] HART_ID   = '0,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EX_VALID,
    input  logic [XLEN-1:0] EX_PC,
    input  logic [31:0]     EX_INSTR,
    input  logic            EX_WE,
    input  logic [XLEN-1:0] EX_RD,
    input  logic [XLEN-1:0] EX_CSRD,
    input  logic [4:0]      ID_RS1_ADDR,
    input  logic [4:0]      ID_RS2_ADDR,
    output logic [XLEN-1:0] ID_RS1,
    output logic [XLEN-1:0] ID_RS2,
    input  logic [11:0]     ID_CSR_ADDR,
    output logic [XLEN-1:0] ID_RCSR,
    output logic [XLEN-1:0] MSTATUS,
    output logic [1:0]      MODE,
    output logic            WB_PC_WE,
    output logic [XLEN-1:0] WB_NEXT_PC,
    output logic            WB_FLUSH
);

    mstatus_t        mstatus_q;
    logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q;
    logic [XLEN-1:0] mcause_q, mtval_q, mip_q;
    logic [XLEN-1:0] mcycle_q, minstret_q;
    logic [1:0]      mode_q;

    logic [4:0]      rd_a, rs1_f;
    logic [11:0]     csr_a;
    csr_op_e         op;
    logic            csr_wr, is_mret;
    logic [XLEN-1:0] csr_wdata;
    logic            unused_pc;

    assign rd_a    = EX_INSTR[11:7];
    assign rs1_f   = EX_INSTR[19:15];
    assign csr_a   = EX_INSTR[31:20];
    assign op      = csr_op(EX_INSTR[14:12]);
    assign is_mret = EX_VALID && (EX_INSTR == INSTR_MRET);

    // Set/clear forms with a zero rs1 field are pure reads.
    assign csr_wr = EX_VALID && EX_WE
                 && (EX_INSTR[6:0] == OPC_SYSTEM)
                 && (op != CSR_NONE)
                 && (op == CSR_WRITE || rs1_f != 5'd0);

    assign csr_wdata = (csr_a == CSR_MEPC) ? {EX_CSRD[XLEN-1:2], 2'b00} : EX_CSRD;
    assign unused_pc = ^EX_PC;

    leve1_regfile #(.XLEN(XLEN)) u_rf (
        .clk_i    (CLK),
        .rst_i    (RST),
        .we_i     (EX_VALID && EX_WE),
        .waddr_i  (rd_a),
        .wdata_i  (EX_RD),
        .raddr1_i (ID_RS1_ADDR),
        .raddr2_i (ID_RS2_ADDR),
        .rdata1_o (ID_RS1),
        .rdata2_o (ID_RS2)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            mstatus_q  <= MSTATUS_RST;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            mode_q     <= MODE_M;
        end else begin
            if (csr_wr) begin
                case (csr_a)
                    CSR_MSTATUS:  mstatus_q  <= csr_wdata;
                    CSR_MIE:      mie_q      <= csr_wdata;
                    CSR_MTVEC:    mtvec_q    <= csr_wdata;
                    CSR_MSCRATCH: mscratch_q <= csr_wdata;
                    CSR_MEPC:     mepc_q     <= csr_wdata;
                    CSR_MCAUSE:   mcause_q   <= csr_wdata;
                    CSR_MTVAL:    mtval_q    <= csr_wdata;
                    CSR_MIP:      mip_q      <= csr_wdata;
                    default: ;
                endcase
            end
            mcycle_q <= (csr_wr && csr_a == CSR_MCYCLE)
                      ? csr_wdata : mcycle_q + 1'b1;
            minstret_q <= (csr_wr && csr_a == CSR_MINSTRET)
                        ? csr_wdata
                        : minstret_q + {{(XLEN-1){1'b0}}, EX_VALID};
            // mpp sampled before the new image lands; 01/10 are not supported.
            if (is_mret) begin
                mstatus_q <= EX_CSRD;
                mode_q    <= (mstatus_q.f.mpp == MODE_M) ? MODE_M : MODE_U;
            end
        end
    end

    always_comb begin
        ID_RCSR = '0;
        case (ID_CSR_ADDR)
            CSR_MSTATUS:              ID_RCSR = mstatus_q;
            CSR_MISA:                 ID_RCSR = MISA_VAL;
            CSR_MIE:                  ID_RCSR = mie_q;
            CSR_MTVEC:                ID_RCSR = mtvec_q;
            CSR_MSCRATCH:             ID_RCSR = mscratch_q;
            CSR_MEPC:                 ID_RCSR = mepc_q;
            CSR_MCAUSE:               ID_RCSR = mcause_q;
            CSR_MTVAL:                ID_RCSR = mtval_q;
            CSR_MIP:                  ID_RCSR = mip_q;
            CSR_MCYCLE, CSR_CYCLE:    ID_RCSR = mcycle_q;
            CSR_MINSTRET, CSR_INSTRET: ID_RCSR = minstret_q;
            CSR_MHARTID:              ID_RCSR = HART_ID;
            default:                  ID_RCSR = '0;
        endcase
        if (csr_wr && csr_rw(csr_a) && csr_a == ID_CSR_ADDR) ID_RCSR = csr_wdata;
        if (is_mret && ID_CSR_ADDR == CSR_MSTATUS) ID_RCSR = EX_CSRD;
    end

    assign MSTATUS    = mstatus_q;
    assign MODE       = mode_q;
    assign WB_PC_WE   = is_mret;
    assign WB_FLUSH   = is_mret;
    assign WB_NEXT_PC = mepc_q;

endmodule

// File: tb/tb_leve1_wb_csr.sv
// Directed bench for leve1_wb_csr: reset, GPR commit/bypass,
// CSR writes, MRET, counters and reset during commit.
module tb_leve1_wb_csr;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EX_VALID, EX_WE;
    logic [63:0] EX_PC, EX_RD, EX_CSRD;
    logic [31:0] EX_INSTR;
    logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR;
    logic [63:0] ID_RS1, ID_RS2, ID_RCSR, MSTATUS, WB_NEXT_PC;
    logic [11:0] ID_CSR_ADDR;
    logic [1:0]  MODE;
    logic        WB_PC_WE, WB_FLUSH;

    int passed = 0;
    int total  = 0;

    localparam logic [63:0] MISA = 64'h8000_0000_0010_1100;

    leve1_wb_csr dut (
        .CLK(CLK), .RST(RST),
        .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_INSTR(EX_INSTR),
        .EX_WE(EX_WE), .EX_RD(EX_RD), .EX_CSRD(EX_CSRD),
        .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_CSR_ADDR(ID_CSR_ADDR), .ID_RCSR(ID_RCSR),
        .MSTATUS(MSTATUS), .MODE(MODE),
        .WB_PC_WE(WB_PC_WE), .WB_NEXT_PC(WB_NEXT_PC), .WB_FLUSH(WB_FLUSH)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] csri(input logic [11:0] a,
                                         input logic [4:0] rs1,
                                         input logic [2:0] f3);
        return {a, rs1, f3, 5'd0, 7'b1110011};
    endfunction

    function automatic logic [31:0] add_rd(input logic [4:0] rd);
        return {17'd0, 3'd0, rd, 7'b0110011};
    endfunction

    task automatic idle();
        EX_VALID = 1'b0;
        EX_WE    = 1'b0;
        EX_PC    = '0;
        EX_INSTR = 32'h0000_0013;
        EX_RD    = '0;
        EX_CSRD  = '0;
    endtask

    // One commit edge, then idle inputs and settle.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        idle();
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        ID_CSR_ADDR = 12'h301;
        ID_RS1_ADDR = 5'd5;
        #1;
        total++;
        if (MODE !== 2'b11) $display("FAIL rst_mode got %h want 3", MODE);
        else passed++;
        total++;
        if (MSTATUS !== 64'h0000_000A_0000_0000)
            $display("FAIL rst_mstatus got %h want 0000000a00000000", MSTATUS);
        else passed++;
        total++;
        if (ID_RCSR !== MISA) $display("FAIL rst_misa got %h want %h", ID_RCSR, MISA);
        else passed++;
        ID_CSR_ADDR = 12'hB00;
        #1;
        total++;
        if (ID_RCSR !== 64'h0) $display("FAIL rst_mcycle got %h want 0", ID_RCSR);
        else passed++;
        total++;
        if (ID_RS1 !== 64'h0) $display("FAIL rst_gpr got %h want 0", ID_RS1);
        else passed++;
    endtask

    task automatic test_gpr();
        EX_VALID = 1'b1; EX_WE = 1'b1;
        EX_INSTR = add_rd(5'd5); EX_RD = 64'hDEAD;
        ID_RS1_ADDR = 5'd5;
        #1;
        total++;
        if (ID_RS1 !== 64'hDEAD) $display("FAIL gpr_bypass got %h want dead", ID_RS1);
        else passed++;
        tick();
        total++;
        if (ID_RS1 !== 64'hDEAD) $display("FAIL gpr_state got %h want dead", ID_RS1);
        else passed++;
        EX_VALID = 1'b1; EX_WE = 1'b1;
        EX_INSTR = add_rd(5'd0); EX_RD = 64'hBEEF;
        ID_RS2_ADDR = 5'd0;
        #1;
        total++;
        if (ID_RS2 !== 64'h0) $display("FAIL x0_bypass got %h want 0", ID_RS2);
        else passed++;
        tick();
        total++;
        if (ID_RS2 !== 64'h0) $display("FAIL x0_state got %h want 0", ID_RS2);
        else passed++;
    endtask

    task automatic test_csr();
        ID_CSR_ADDR = 12'h340;
        EX_VALID = 1'b1; EX_WE = 1'b1;
        EX_INSTR = csri(12'h340, 5'd1, 3'b001); EX_CSRD = 64'h1234;
        #1;
        total++;
        if (ID_RCSR !== 64'h1234) $display("FAIL csrrw_bypass got %h want 1234", ID_RCSR);
        else passed++;
        tick();
        total++;
        if (ID_RCSR !== 64'h1234) $display("FAIL csrrw_state got %h want 1234", ID_RCSR);
        else passed++;
        EX_VALID = 1'b1; EX_WE = 1'b1;
        EX_INSTR = csri(12'h340, 5'd0, 3'b010); EX_CSRD = 64'h0;
        #1;
        total++;
        if (ID_RCSR !== 64'h1234) $display("FAIL csrrs0_comb got %h want 1234", ID_RCSR);
        else passed++;
        tick();
        total++;
        if (ID_RCSR !== 64'h1234) $display("FAIL csrrs0_state got %h want 1234", ID_RCSR);
        else passed++;
        EX_VALID = 1'b1; EX_WE = 1'b0;
        EX_INSTR = csri(12'h340, 5'd1, 3'b001); EX_CSRD = 64'h5555;
        tick();
        total++;
        if (ID_RCSR !== 64'h1234) $display("FAIL csr_no_we got %h want 1234", ID_RCSR);
        else passed++;
        ID_CSR_ADDR = 12'h301;
        EX_VALID = 1'b1; EX_WE = 1'b1;
        EX_INSTR = csri(12'h301, 5'd1, 3'b001); EX_CSRD = 64'hFFFF;
        #1;
        total++;
        if (ID_RCSR !== MISA) $display("FAIL misa_comb got %h want %h", ID_RCSR, MISA);
        else passed++;
        tick();
        total++;
        if (ID_RCSR !== MISA) $display("FAIL misa_state got %h want %h", ID_RCSR, MISA);
        else passed++;
        ID_CSR_ADDR = 12'h341;
        EX_VALID = 1'b1; EX_WE = 1'b1;
        EX_INSTR = csri(12'h341, 5'd2, 3'b001); EX_CSRD = 64'h8000_0103;
        tick();
        total++;
        if (ID_RCSR !== 64'h8000_0100) $display("FAIL mepc_align got %h want 80000100", ID_RCSR);
        else passed++;
    endtask

    task automatic test_mret();
        ID_CSR_ADDR = 12'h300;
        EX_VALID = 1'b1; EX_WE = 1'b0;
        EX_INSTR = 32'h3020_0073; EX_CSRD = 64'h80;
        #1;
        total++;
        if (WB_PC_WE !== 1'b1 || WB_FLUSH !== 1'b1)
            $display("FAIL mret_redirect got %b%b want 11", WB_PC_WE, WB_FLUSH);
        else passed++;
        total++;
        if (WB_NEXT_PC !== 64'h8000_0100) $display("FAIL mret_pc got %h want 80000100", WB_NEXT_PC);
        else passed++;
        total++;
        if (ID_RCSR !== 64'h80) $display("FAIL mret_bypass got %h want 80", ID_RCSR);
        else passed++;
        tick();
        total++;
        if (MODE !== 2'b00) $display("FAIL mret_mode got %h want 0", MODE);
        else passed++;
        total++;
        if (MSTATUS !== 64'h80) $display("FAIL mret_mstatus got %h want 80", MSTATUS);
        else passed++;
        total++;
        if (WB_PC_WE !== 1'b0 || WB_FLUSH !== 1'b0)
            $display("FAIL idle_redirect got %b%b want 00", WB_PC_WE, WB_FLUSH);
        else passed++;
        EX_VALID = 1'b1; EX_WE = 1'b1;
        EX_INSTR = csri(12'h300, 5'd1, 3'b001); EX_CSRD = 64'h1800;
        tick();
        EX_VALID = 1'b1; EX_INSTR = 32'h3020_0073; EX_CSRD = 64'h0;
        tick();
        total++;
        if (MODE !== 2'b11) $display("FAIL mret_mpp11 got %h want 3", MODE);
        else passed++;
        EX_VALID = 1'b1; EX_WE = 1'b1;
        EX_INSTR = csri(12'h300, 5'd1, 3'b001); EX_CSRD = 64'h1000;
        tick();
        EX_VALID = 1'b1; EX_INSTR = 32'h3020_0073; EX_CSRD = 64'h0;
        tick();
        total++;
        if (MODE !== 2'b00) $display("FAIL mret_mpp10 got %h want 0", MODE);
        else passed++;
    endtask

    task automatic test_counters();
        ID_CSR_ADDR = 12'hB02;
        EX_VALID = 1'b1; EX_WE = 1'b1;
        EX_INSTR = csri(12'hB02, 5'd1, 3'b001); EX_CSRD = '1;
        tick();
        total++;
        if (ID_RCSR !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL minstret_wr got %h want all-ones", ID_RCSR);
        else passed++;
        EX_VALID = 1'b1; EX_WE = 1'b0; EX_INSTR = 32'h0000_0013;
        tick();
        ID_CSR_ADDR = 12'hC02;
        #1;
        total++;
        if (ID_RCSR !== 64'h0) $display("FAIL minstret_wrap got %h want 0", ID_RCSR);
        else passed++;
        ID_CSR_ADDR = 12'hB00;
        EX_VALID = 1'b1; EX_WE = 1'b1;
        EX_INSTR = csri(12'hB00, 5'd1, 3'b001); EX_CSRD = 64'd100;
        tick();
        total++;
        if (ID_RCSR !== 64'd100) $display("FAIL mcycle_wr got %0d want 100", ID_RCSR);
        else passed++;
        tick();
        ID_CSR_ADDR = 12'hC00;
        #1;
        total++;
        if (ID_RCSR !== 64'd101) $display("FAIL mcycle_inc got %0d want 101", ID_RCSR);
        else passed++;
        EX_VALID = 1'b1; EX_WE = 1'b0; EX_INSTR = 32'h0;
        tick();
        ID_CSR_ADDR = 12'hC02;
        #1;
        total++;
        if (ID_RCSR !== 64'd2) $display("FAIL instret_illegal got %0d want 2", ID_RCSR);
        else passed++;
    endtask

    task automatic test_reset_mid_commit();
        EX_VALID = 1'b1; EX_WE = 1'b1;
        EX_INSTR = add_rd(5'd7); EX_RD = 64'hAA;
        tick();
        RST = 1'b1;
        EX_VALID = 1'b1; EX_WE = 1'b1;
        EX_INSTR = add_rd(5'd7); EX_RD = 64'h55;
        tick();
        RST = 1'b0;
        ID_RS1_ADDR = 5'd7;
        #1;
        total++;
        if (ID_RS1 !== 64'h0) $display("FAIL rst_commit_gpr got %h want 0", ID_RS1);
        else passed++;
        total++;
        if (MODE !== 2'b11) $display("FAIL rst_commit_mode got %h want 3", MODE);
        else passed++;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        ID_RS1_ADDR = '0;
        ID_RS2_ADDR = '0;
        ID_CSR_ADDR = '0;
        @(negedge CLK);
        test_reset();
        test_gpr();
        test_csr();
        test_mret();
        test_counters();
        test_reset_mid_commit();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
